// File: rtl/shiftregtx_buf.sv
// rtl/shiftregtx_buf.sv - double-buffered SPI TX serializer with per-word length and bit order
// Optional even-parity bit per frame when SHIFTREGTX_PARITY_EN is defined.
module shiftregtx_buf #(
   parameter int SIZE  = 8,
   parameter int CNT_W = 4
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             En,
   input  logic             Abort,
   input  logic [SIZE-1:0]  DataIn,
   input  logic [CNT_W-1:0] Len,
   input  logic             LsbFirst,
   input  logic             DataValid,
   output logic             DataReady,
   output logic             SerOut,
   output logic             Busy,
   output logic             FrameDone
);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(SIZE);

   // One spare bit past the data holds the parity bit, so both builds share a datapath.
   function automatic logic [SIZE:0] build_word(
      input logic [SIZE-1:0]  d,
      input logic [CNT_W-1:0] l,
      input logic             lsb
   );
      logic [SIZE-1:0] m;
      logic [SIZE:0]   w;
      m = d & ~({SIZE{1'b1}} << l);
      if (lsb) begin
         w = {1'b0, m};
`ifdef SHIFTREGTX_PARITY_EN
         w = w | ({{SIZE{1'b0}}, ^m} << l);
`endif
      end else begin
         w = {1'b0, m} << (SIZE + 1 - int'(l));
`ifdef SHIFTREGTX_PARITY_EN
         w = w | ({{SIZE{1'b0}}, ^m} << (SIZE - int'(l)));
`endif
      end
      return w;
   endfunction

   state_t            state;
   state_t            state_next;

   logic [SIZE:0]     sreg;
   logic              cur_lsb;
   logic [CNT_W-1:0]  cur_last;
   logic [CNT_W-1:0]  cnt;

   logic [SIZE:0]     buf_word;
   logic              buf_lsb;
   logic [CNT_W-1:0]  buf_last;
   logic              buf_full;

   logic              frame_done;

   logic [CNT_W-1:0]  len_eff;
   logic [CNT_W-1:0]  in_last;
   logic [SIZE:0]     in_word;

   logic              accept;
   logic              final_tick;
   logic              load_in;
   logic              load_buf;
   logic              wr_buf;

   assign len_eff = ((Len == '0) || (Len > SIZE_C)) ? SIZE_C : Len;
`ifdef SHIFTREGTX_PARITY_EN
   assign in_last = len_eff;
`else
   assign in_last = len_eff - CNT_W'(1);
`endif
   assign in_word = build_word(DataIn, len_eff, LsbFirst);

   assign DataReady  = ~Abort & ((state == IDLE) | ~buf_full);
   assign accept     = DataValid & DataReady;
   assign final_tick = (state == SHIFT) & En & (cnt == cur_last);

   assign SerOut    = (state == SHIFT) & (cur_lsb ? sreg[0] : sreg[SIZE]);
   assign Busy      = (state == SHIFT);
   assign FrameDone = frame_done;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      load_in    = 1'b0;
      load_buf   = 1'b0;
      wr_buf     = 1'b0;
      if (Abort) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  load_in    = 1'b1;
                  state_next = SHIFT;
               end
            end
            SHIFT: begin
               // A full buffer holds DataReady low, so a final-tick handshake implies an empty buffer.
               if (final_tick) begin
                  if (buf_full) begin
                     load_buf = 1'b1;
                  end else if (accept) begin
                     load_in = 1'b1;
                  end else begin
                     state_next = IDLE;
                  end
               end else if (accept) begin
                  wr_buf = 1'b1;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         sreg       <= '0;
         cur_lsb    <= 1'b0;
         cur_last   <= '0;
         cnt        <= '0;
         buf_word   <= '0;
         buf_lsb    <= 1'b0;
         buf_last   <= '0;
         buf_full   <= 1'b0;
         frame_done <= 1'b0;
      end else if (Abort) begin
         sreg       <= '0;
         cnt        <= '0;
         buf_full   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= final_tick;
         if (load_buf) begin
            sreg     <= buf_word;
            cur_lsb  <= buf_lsb;
            cur_last <= buf_last;
            cnt      <= '0;
            buf_full <= 1'b0;
         end else if (load_in) begin
            sreg     <= in_word;
            cur_lsb  <= LsbFirst;
            cur_last <= in_last;
            cnt      <= '0;
         end else if ((state == SHIFT) && En) begin
            sreg <= cur_lsb ? (sreg >> 1) : (sreg << 1);
            cnt  <= final_tick ? '0 : cnt + CNT_W'(1);
         end
         if (wr_buf) begin
            buf_word <= in_word;
            buf_lsb  <= LsbFirst;
            buf_last <= in_last;
            buf_full <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_shiftregtx_buf.sv
// tb/tb_shiftregtx_buf.sv - directed-vector bench for shiftregtx_buf
// Expected serial sequences are hand-computed; first bit sent is the highest bit of each seq value.
module tb_shiftregtx_buf;

   logic       Clk = 1'b0;
   logic       Rst_n = 1'b0;
   logic       En = 1'b0;
   logic       Abort = 1'b0;
   logic [7:0] DataIn = '0;
   logic [3:0] Len = '0;
   logic       LsbFirst = 1'b0;
   logic       DataValid = 1'b0;
   logic       DataReady;
   logic       SerOut;
   logic       Busy;
   logic       FrameDone;

   int n_checks = 0;
   int n_errors = 0;

   shiftregtx_buf #(.SIZE(8), .CNT_W(4)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .En(En), .Abort(Abort),
      .DataIn(DataIn), .Len(Len), .LsbFirst(LsbFirst),
      .DataValid(DataValid), .DataReady(DataReady),
      .SerOut(SerOut), .Busy(Busy), .FrameDone(FrameDone)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic handshake(input logic [7:0] d, input logic [3:0] l, input logic lsb);
      DataIn    = d;
      Len       = l;
      LsbFirst  = lsb;
      DataValid = 1'b1;
      tick();
      DataValid = 1'b0;
      DataIn    = 8'h00;
   endtask

   // Send one frame with En pulsing once every `period` cycles and check every cycle.
   task automatic do_frame(input string tag, input logic [7:0] d, input logic [3:0] l,
                           input logic lsb, input int n, input logic [31:0] seq, input int period);
      handshake(d, l, lsb);
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < period; k++) begin
            En = (k == period - 1);
            check({tag, "_ser"}, SerOut, seq[n-1-i]);
            check({tag, "_busy"}, Busy, 1'b1);
            check({tag, "_nodone"}, FrameDone, 1'b0);
            tick();
         end
      end
      check({tag, "_done"}, FrameDone, 1'b1);
      check({tag, "_idle"}, Busy, 1'b0);
      check({tag, "_ser_idle"}, SerOut, 1'b0);
      En = 1'b0;
      tick();
      check({tag, "_done_pulse"}, FrameDone, 1'b0);
   endtask

   initial begin
      #2;
      check("rst_ser", SerOut, 1'b0);
      check("rst_busy", Busy, 1'b0);
      check("rst_done", FrameDone, 1'b0);
      check("rst_ready", DataReady, 1'b1);
      repeat (2) @(posedge Clk);
      #1;
      Rst_n = 1'b1;
      tick();

      // Reset mid-frame, then confirm nothing residual leaks out.
      En = 1'b1;
      handshake(8'hFF, 4'd8, 1'b0);
      tick();
      tick();
      check("midrst_pre_busy", Busy, 1'b1);
      Rst_n = 1'b0;
      #1;
      check("midrst_ser", SerOut, 1'b0);
      check("midrst_busy", Busy, 1'b0);
      check("midrst_done", FrameDone, 1'b0);
      check("midrst_ready", DataReady, 1'b1);
      tick();
      Rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("postrst_ser", SerOut, 1'b0);
         check("postrst_done", FrameDone, 1'b0);
      end
      En = 1'b0;

      do_frame("msb_a5", 8'hA5, 4'd8, 1'b0, 8, 32'b10100101, 1);
      do_frame("lsb_f3", 8'hF3, 4'd5, 1'b1, 5, 32'b11001, 1);
      do_frame("len0", 8'hA5, 4'd0, 1'b0, 8, 32'b10100101, 1);
      do_frame("len5_msb", 8'hFF, 4'd5, 1'b0, 5, 32'b11111, 1);
      do_frame("len12", 8'h3C, 4'd12, 1'b1, 8, 32'b00111100, 1);
      do_frame("slow_81", 8'h81, 4'd8, 1'b0, 8, 32'b10000001, 3);

      // Back-to-back frames through the holding buffer.
      En = 1'b1;
      handshake(8'h0F, 4'd8, 1'b0);
      for (int i = 0; i < 16; i++) begin
         logic [15:0] seq;
         seq = 16'h0FF0;
         if (i == 0) begin
            DataIn    = 8'hF0;
            Len       = 4'd8;
            LsbFirst  = 1'b0;
            DataValid = 1'b1;
         end
         check("b2b_ser", SerOut, seq[15-i]);
         check("b2b_busy", Busy, 1'b1);
         check("b2b_ready", DataReady, (i == 0) || (i >= 8));
         check("b2b_done", FrameDone, (i == 8));
         tick();
         DataValid = 1'b0;
      end
      check("b2b_done2", FrameDone, 1'b1);
      check("b2b_idle", Busy, 1'b0);
      tick();

      // Abort with the buffer full.
      handshake(8'hA5, 4'd8, 1'b0);
      DataIn    = 8'h3C;
      DataValid = 1'b1;
      tick();
      DataValid = 1'b0;
      tick();
      tick();
      check("abort_pre_ser", SerOut, 1'b0);
      check("abort_pre_ready", DataReady, 1'b0);
      Abort = 1'b1;
      #1;
      check("abort_ready_comb", DataReady, 1'b0);
      tick();
      Abort = 1'b0;
      #1;
      check("abort_busy", Busy, 1'b0);
      check("abort_ser", SerOut, 1'b0);
      check("abort_ready", DataReady, 1'b1);
      check("abort_done", FrameDone, 1'b0);
      for (int i = 0; i < 12; i++) begin
         tick();
         check("abort_quiet_ser", SerOut, 1'b0);
         check("abort_quiet_done", FrameDone, 1'b0);
         check("abort_quiet_busy", Busy, 1'b0);
      end
      En = 1'b0;

      do_frame("after_abort", 8'h5A, 4'd8, 1'b1, 8, 32'b01011010, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
